// File: rtl/wgt_buf_loader.sv
// wgt_buf_loader: fills the 256-entry ping-pong weight buffer from a weight stream.
// Define WGT_LOADER_STALL_CNT_EN to add the stall_cnt output.
module wgt_buf_loader #(
    parameter int         DATA_WID = 16,
    parameter logic [7:0] MID_ADDR = 8'h80
) (
    input  logic                clock,
    input  logic                rst_n,
    input  logic                load_start,
    input  logic [6:0]          chn_num,
    input  logic [3:0]          kernel_size,
    input  logic                s_valid,
    input  logic [DATA_WID-1:0] s_data,
    output logic                s_ready,
    input  logic                half_release,
    input  logic                release_sel,
    output logic                wgt_wr_en,
    output logic [7:0]          wgt_wr_addr,
    output logic [DATA_WID-1:0] wgt_wr_data,
    output logic [1:0]          half_full,
    output logic                load_done,
    output logic                load_half,
    output logic                busy,
    output logic                cfg_err
`ifdef WGT_LOADER_STALL_CNT_EN
    ,
    output logic [15:0]         stall_cnt
`endif
);
    typedef enum logic [2:0] {IDLE, CHECK, WAIT_FREE, LOAD, DONE} state_t;
    state_t      state;
    logic        wr_ptr, tgt;
    logic [6:0]  chn_r;
    logic [3:0]  ks_r;
    logic [7:0]  addr;
    logic [13:0] wcnt;
    logic [6:0]  ksq;
    logic [13:0] total;
    logic        cfg_bad, hs;
    logic [1:0]  hf_next;
    logic [7:0]  base;

    assign ksq     = 7'(ks_r) * 7'(ks_r);
    assign total   = (14'(chn_r) + 14'd1) * 14'(ksq);
    assign cfg_bad = !ks_r[0] || ks_r > 4'd11 || total > 14'd128;
    assign s_ready = state == LOAD;
    assign hs      = s_valid && s_ready;
    assign busy    = state != IDLE;
    assign base    = tgt ? MID_ADDR : 8'h00;

    // Release first, then the DONE set, so a same-half collision keeps the half full.
    always_comb begin
        hf_next = half_full;
        if (half_release) hf_next[release_sel] = 1'b0;
        if (state == DONE) hf_next[tgt] = 1'b1;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wr_ptr      <= 1'b0;
            tgt         <= 1'b0;
            chn_r       <= '0;
            ks_r        <= '0;
            addr        <= '0;
            wcnt        <= '0;
            half_full   <= 2'b00;
            load_half   <= 1'b0;
            load_done   <= 1'b0;
            cfg_err     <= 1'b0;
            wgt_wr_en   <= 1'b0;
            wgt_wr_addr <= '0;
            wgt_wr_data <= '0;
        end else begin
            wgt_wr_en <= hs;
            load_done <= 1'b0;
            cfg_err   <= 1'b0;
            half_full <= hf_next;
            if (hs) begin
                wgt_wr_addr <= addr;
                wgt_wr_data <= s_data;
                addr        <= addr + 8'd1;
                wcnt        <= wcnt + 14'd1;
            end
            case (state)
                IDLE: if (load_start) begin
                    chn_r <= chn_num;
                    ks_r  <= kernel_size;
                    tgt   <= wr_ptr;
                    state <= CHECK;
                end
                CHECK: begin
                    if (cfg_bad) begin
                        cfg_err <= 1'b1;
                        state   <= IDLE;
                    end else if (half_full[tgt]) begin
                        state <= WAIT_FREE;
                    end else begin
                        addr  <= base;
                        wcnt  <= '0;
                        state <= LOAD;
                    end
                end
                WAIT_FREE: if (!half_full[tgt]) begin
                    addr  <= base;
                    wcnt  <= '0;
                    state <= LOAD;
                end
                LOAD: if (hs && wcnt == total - 14'd1) state <= DONE;
                DONE: begin
                    load_done <= 1'b1;
                    load_half <= tgt;
                    wr_ptr    <= ~wr_ptr;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WGT_LOADER_STALL_CNT_EN
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (state == IDLE && load_start)
            stall_cnt <= '0;
        else if (((state == LOAD && !s_valid) || state == WAIT_FREE) && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_wgt_buf_loader.sv
// tb_wgt_buf_loader: scoreboard bench for wgt_buf_loader; writes and load_done
// are predicted at handshake time and checked by an independent monitor.
module tb_wgt_buf_loader;
    logic        clock = 0, rst_n = 0, load_start = 0, s_valid = 0;
    logic        half_release = 0, release_sel = 0;
    logic [6:0]  chn_num = 0;
    logic [3:0]  kernel_size = 0;
    logic [15:0] s_data = 0;
    logic        s_ready, wgt_wr_en, load_done, load_half, busy, cfg_err;
    logic [7:0]  wgt_wr_addr;
    logic [15:0] wgt_wr_data;
    logic [1:0]  half_full;
`ifdef WGT_LOADER_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    typedef struct {
        logic [7:0]  a;
        logic [15:0] d;
        int          c;
    } wr_t;
    wr_t  exp_q[$];
    logic exp_h[$];
    wr_t  mon_e;
    logic mon_h;
    int   checks = 0, errors = 0, cyc = 0, cfg_seen = 0;

    wgt_buf_loader dut (
        .clock(clock), .rst_n(rst_n), .load_start(load_start), .chn_num(chn_num),
        .kernel_size(kernel_size), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .half_release(half_release), .release_sel(release_sel), .wgt_wr_en(wgt_wr_en),
        .wgt_wr_addr(wgt_wr_addr), .wgt_wr_data(wgt_wr_data), .half_full(half_full),
        .load_done(load_done), .load_half(load_half), .busy(busy), .cfg_err(cfg_err)
`ifdef WGT_LOADER_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clock) if (rst_n) begin
        if (wgt_wr_en) begin
            if (exp_q.size() == 0) check("unexpected_write", wgt_wr_en, 0);
            else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", wgt_wr_addr, mon_e.a);
                check("wr_data", wgt_wr_data, mon_e.d);
                check("wr_cycle", cyc, mon_e.c);
            end
        end
        if (load_done) begin
            if (exp_h.size() == 0) check("unexpected_done", load_done, 0);
            else begin
                mon_h = exp_h.pop_front();
                check("load_half", load_half, mon_h);
            end
        end
        if (cfg_err) cfg_seen++;
    end

    task automatic start(input logic [3:0] k, input logic [6:0] c);
        load_start = 1; kernel_size = k; chn_num = c;
        @(posedge clock); #1;
        load_start = 0;
    endtask

    task automatic release_half(input logic sel);
        half_release = 1; release_sel = sel;
        @(posedge clock); #1;
        half_release = 0;
    endtask

    // With tog set, s_valid drops for one cycle after every accepted word.
    task automatic send(input int n, input logic [15:0] d0, input logic [7:0] a0, input bit tog);
        int i = 0, g = 0;
        bit hs;
        s_valid = 1;
        while (i < n && g < 1000) begin
            s_data = d0 + 16'(i);
            @(negedge clock);
            hs = s_valid && s_ready;
            if (hs) begin
                exp_q.push_back('{a0 + 8'(i), d0 + 16'(i), cyc + 1});
                i++;
            end
            g++;
            @(posedge clock); #1;
            s_valid = (i < n) && !(tog && hs);
        end
        s_valid = 0;
        if (i < n) check("send_timeout", i, n);
    endtask

    task automatic wait_idle();
        int g = 0;
        @(negedge clock);
        while (busy && g < 400) begin
            @(negedge clock);
            g++;
        end
        check("idle_timeout", busy, 0);
        @(posedge clock); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", busy, 0);
        check("rst_half_full", half_full, 2'b00);
        check("rst_wr_en", wgt_wr_en, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_load_half", load_half, 0);
        check("rst_cfg_err", cfg_err, 0);
        rst_n = 1;
        @(posedge clock); #1;

        exp_h.push_back(1'b0);
        start(4'd3, 7'd1);
        send(18, 16'h0001, 8'h00, 0);
        wait_idle();
        check("l1_half_full", half_full, 2'b01);
        check("l1_load_half", load_half, 0);

        exp_h.push_back(1'b1);
        start(4'd1, 7'd127);
        send(128, 16'h0100, 8'h80, 0);
        wait_idle();
        check("l2_half_full", half_full, 2'b11);
        check("l2_load_half", load_half, 1);

        start(4'd3, 7'd0);
        repeat (3) @(posedge clock);
        #1;
        check("wf_busy", busy, 1);
        check("wf_s_ready", s_ready, 0);
        release_half(1'b0);
        check("wf_half_full", half_full, 2'b10);
        check("wf_still_wait", s_ready, 0);
        @(posedge clock); #1;
        check("wf_load_begins", s_ready, 1);
        exp_h.push_back(1'b0);
        send(9, 16'h0200, 8'h00, 0);
        wait_idle();
        check("l3_half_full", half_full, 2'b11);
        check("l3_load_half", load_half, 0);

        release_half(1'b0);
        release_half(1'b1);
        check("rel_both", half_full, 2'b00);

        start(4'd11, 7'd1);
        wait_idle();
        check("cfg_big", cfg_seen, 1);
        start(4'd4, 7'd0);
        wait_idle();
        check("cfg_even", cfg_seen, 2);
        start(4'd9, 7'd1);
        wait_idle();
        check("cfg_total", cfg_seen, 3);
        check("cfg_half_full", half_full, 2'b00);

        exp_h.push_back(1'b1);
        start(4'd1, 7'd0);
        send(1, 16'hBEEF, 8'h80, 0);
        wait_idle();
        check("ptr_half_full", half_full, 2'b10);
        release_half(1'b0);
        check("rel_empty", half_full, 2'b10);

        exp_h.push_back(1'b0);
        start(4'd5, 7'd0);
        send(25, 16'h0300, 8'h00, 1);
        wait_idle();
        check("l5_half_full", half_full, 2'b11);
        check("l5_load_half", load_half, 0);
`ifdef WGT_LOADER_STALL_CNT_EN
        check("stall_cnt", stall_cnt, 24);
`endif
        check("done_q_empty", exp_h.size(), 0);

        release_half(1'b1);
        start(4'd5, 7'd0);
        send(10, 16'h0400, 8'h80, 0);
        exp_q.delete();
        rst_n = 0;
        #1;
        check("arst_wr_en", wgt_wr_en, 0);
        check("arst_half_full", half_full, 2'b00);
        check("arst_busy", busy, 0);
        check("arst_s_ready", s_ready, 0);
        repeat (2) @(posedge clock);
        #1;
        rst_n = 1;
        repeat (2) @(posedge clock);
        #1;
        check("post_rst_idle", busy, 0);
        check("wr_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
